// File: rtl/rv32_regfile_mp.sv
// Multi-read-port rv32 integer register file with a post-reset hardware clear sweep.
// Same-cycle write-to-read forwarding is enabled by defining RV32_REGFILE_BYPASS_EN.
module rv32_regfile_mp #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned READ_PORTS = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    stall_in,
  input  logic                                    writeback_flush_in,
  input  logic [READ_PORTS*$clog2(NREGS)-1:0]     rs_in,
  input  logic [$clog2(NREGS)-1:0]                rd_in,
  input  logic                                    rd_write_in,
  input  logic [XLEN-1:0]                         rd_value_in,
  output logic [READ_PORTS*XLEN-1:0]              rs_value_out,
  output logic                                    ready_out
);

  localparam int unsigned AW = $clog2(NREGS);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [AW-1:0]   rs_q [READ_PORTS];
  logic [AW-1:0]   rs_d [READ_PORTS];
  logic [XLEN-1:0] regs_q [NREGS];

  logic            func_we;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  // A functional write is only honoured once the sweep is done; index 0 is never stored.
  assign func_we = (state_q == StReady) && rd_write_in && !writeback_flush_in &&
                   (rd_in != '0);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_en     = 1'b0;
    wr_addr   = rd_in;
    wr_data   = rd_value_in;
    if (!reset) begin
      unique case (state_q)
        StClear: begin
          wr_en     = 1'b1;
          wr_addr   = clr_idx_q;
          wr_data   = '0;
          clr_idx_d = clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(NREGS - 1)) begin
            state_d = StReady;
          end
        end
        StReady: begin
          wr_en = func_we;
        end
        default: begin
          state_d = StClear;
        end
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < int'(READ_PORTS); p++) begin
      rs_d[p] = stall_in ? rs_q[p] : rs_in[p*AW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClear;
      clr_idx_q <= AW'(1);
      for (int p = 0; p < int'(READ_PORTS); p++) begin
        rs_q[p] <= '0;
      end
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      for (int p = 0; p < int'(READ_PORTS); p++) begin
        rs_q[p] <= rs_d[p];
      end
    end
  end

  // Array has no reset of its own; the clear sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_value_out = '0;
    for (int p = 0; p < int'(READ_PORTS); p++) begin
      rs_value_out[p*XLEN +: XLEN] = (rs_q[p] == '0) ? '0 : regs_q[rs_q[p]];
`ifdef RV32_REGFILE_BYPASS_EN
      if (func_we && (rd_in == rs_q[p])) begin
        rs_value_out[p*XLEN +: XLEN] = rd_value_in;
      end
`endif
    end
  end

  assign ready_out = (state_q == StReady);

endmodule
